// File: rtl/edge_pkg.sv
// Shared state encoding for the pulse-to-level reconstructor.
package edge_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_LOW     = 2'd0,
    ST_HOLD_HI = 2'd1,
    ST_HIGH    = 2'd2,
    ST_HOLD_LO = 2'd3
  } state_e;

endpackage

// File: rtl/pulse_to_level_hold_counter.sv
// Down-counter timing the minimum high/low hold intervals.
module hold_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] loadVal_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the count saturates at zero instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = loadVal_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pulse_to_level.sv
// Rebuilds a registered level from rise/fall event pulses with minimum hold
// times, deferring opposite edges that arrive during a hold.
module pulse_to_level
  import edge_pkg::*;
#(
  parameter int MIN_HIGH = 4,
  parameter int MIN_LOW  = 4,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic rise_in,
  input  logic fall_in,
  output logic level_out,
  output logic holding,
  output logic pending,
  output logic err_dup,
  output logic err_simul
);

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW - 1);

  state_e           state_q;
  logic             level_q, holding_q, pending_q, errDup_q, errSimul_q;
  logic             cntLoad, cntDec, cntZero;
  logic [CNT_W-1:0] cntLoadVal;
  logic             riseOnly, fallOnly, simul, effPend;

  assign simul    = rise_in & fall_in;
  assign riseOnly = rise_in & ~fall_in;
  assign fallOnly = fall_in & ~rise_in;

  // Pending flag as it would stand after this cycle's event, so an edge
  // arriving on the final hold cycle is honoured immediately.
  always_comb begin
    effPend    = pending_q;
    cntLoad    = 1'b0;
    cntDec     = 1'b0;
    cntLoadVal = '0;
    unique case (state_q)
      ST_LOW: begin
        cntLoad    = riseOnly;
        cntLoadVal = HIGH_LOAD;
      end
      ST_HIGH: begin
        cntLoad    = fallOnly;
        cntLoadVal = LOW_LOAD;
      end
      ST_HOLD_HI: begin
        effPend    = (pending_q & ~riseOnly) | fallOnly;
        cntLoad    = cntZero & effPend;
        cntLoadVal = LOW_LOAD;
        cntDec     = ~cntZero;
      end
      ST_HOLD_LO: begin
        effPend    = (pending_q & ~fallOnly) | riseOnly;
        cntLoad    = cntZero & effPend;
        cntLoadVal = HIGH_LOAD;
        cntDec     = ~cntZero;
      end
      default: ;
    endcase
  end

  hold_counter #(
    .CNT_W(CNT_W)
  ) uHoldCounter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (cntLoad),
    .loadVal_i(cntLoadVal),
    .dec_i    (cntDec),
    .zero_o   (cntZero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_LOW;
      level_q    <= 1'b0;
      holding_q  <= 1'b0;
      pending_q  <= 1'b0;
      errDup_q   <= 1'b0;
      errSimul_q <= 1'b0;
    end else begin
      errSimul_q <= simul;
      errDup_q   <= 1'b0;
      unique case (state_q)
        ST_LOW: begin
          if (riseOnly) begin
            state_q   <= ST_HOLD_HI;
            level_q   <= 1'b1;
            holding_q <= 1'b1;
          end
          errDup_q <= fallOnly;
        end
        ST_HIGH: begin
          if (fallOnly) begin
            state_q   <= ST_HOLD_LO;
            level_q   <= 1'b0;
            holding_q <= 1'b1;
          end
          errDup_q <= riseOnly;
        end
        ST_HOLD_HI: begin
          // A duplicate is an edge matching the level already queued.
          errDup_q <= (riseOnly & ~pending_q) | (fallOnly & pending_q);
          if (cntZero) begin
            pending_q <= 1'b0;
            if (effPend) begin
              state_q <= ST_HOLD_LO;
              level_q <= 1'b0;
            end else begin
              state_q   <= ST_HIGH;
              holding_q <= 1'b0;
            end
          end else begin
            pending_q <= effPend;
          end
        end
        ST_HOLD_LO: begin
          errDup_q <= (fallOnly & ~pending_q) | (riseOnly & pending_q);
          if (cntZero) begin
            pending_q <= 1'b0;
            if (effPend) begin
              state_q <= ST_HOLD_HI;
              level_q <= 1'b1;
            end else begin
              state_q   <= ST_LOW;
              holding_q <= 1'b0;
            end
          end else begin
            pending_q <= effPend;
          end
        end
        default: state_q <= ST_LOW;
      endcase
    end
  end

  assign level_out = level_q;
  assign holding   = holding_q;
  assign pending   = pending_q;
  assign err_dup   = errDup_q;
  assign err_simul = errSimul_q;

endmodule
